// File: rtl/ram_access_arbiter_pkg.sv
// Shared encodings for the RAM access arbiter: FSM state codes, access sizes,
// RAM direction encoding, grant selector and the busError trap vector.
package ram_access_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam logic [8:0] BUS_ERR_TRAP_VECTOR = 9'd448;

   typedef enum logic {
      GRANT_DATA  = 1'b0,
      GRANT_FETCH = 1'b1
   } grantSel_t;

   // Illegal size codes are reported as misaligned so they share the no-access error path.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addrLo[0];
         SZ_WORD: bad = (addrLo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ram_access_arbiter_timeout.sv
// WAIT-phase cycle counter: cleared at issue, counts while enabled and flags the
// last allowed cycle. TIMEOUT=0 never expires.
module ram_timeout_counter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic resetN,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired && (TIMEOUT != 0)) begin
         count <= count + 1'b1;
      end
   end

   always_comb begin
      expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and load/store, and
// sequences each access through IDLE -> ISSUE -> WAIT -> RESP with registered outputs.
module ram_access_arbiter
   import ram_access_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned MAX_DBURST = 4
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              fReq,
   input  logic [ADDR_W-1:0] fAddr,
   output logic              fDone,
   output logic              fErr,
   input  logic              dReq,
   input  logic              dRW,
   input  logic [1:0]        dSize,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWData,
   output logic              dDone,
   output logic              dErr,
   output logic [DATA_W-1:0] rData,
   output logic              busError,
   output logic              ramMFA,
   output logic              ramRW,
   output logic [1:0]        ramDataSize,
   output logic [ADDR_W-1:0] ramAddress,
   output logic [DATA_W-1:0] ramDataOut,
   input  logic [DATA_W-1:0] ramDataIn,
   input  logic              ramMFC
);

   localparam int unsigned BURST_W = (MAX_DBURST > 0) ? $clog2(MAX_DBURST + 1) : 1;

   logic [1:0]         state;
   logic [1:0]         stateNext;
   grantSel_t          grant;
   grantSel_t          grantNext;
   logic               latRW;
   logic [1:0]         latSize;
   logic [ADDR_W-1:0]  latAddr;
   logic [DATA_W-1:0]  latWData;
   logic [BURST_W-1:0] burstCnt;

   logic fetchWins;
   logic dataWins;
   logic reqBad;
   logic timerExpired;
   logic timeoutHit;
   logic respErr;
   logic enterResp;

   ram_timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) uTimer (
      .clk     (Clk),
      .resetN  (reset),
      .clear   (state == ST_ISSUE),
      .enable  (state == ST_WAIT),
      .expired (timerExpired)
   );

   // Data has priority until MAX_DBURST data grants have gone by with a fetch waiting.
   always_comb begin
      fetchWins  = fReq && (!dReq || (burstCnt == BURST_W'(MAX_DBURST)));
      dataWins   = dReq && !fetchWins;
      reqBad     = fetchWins ? isMisaligned(SZ_WORD, fAddr[1:0])
                             : isMisaligned(dSize, dAddr[1:0]);
      timeoutHit = (state == ST_WAIT) && !ramMFC && timerExpired;

      stateNext = state;
      grantNext = grant;
      respErr   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fetchWins || dataWins) begin
               grantNext = fetchWins ? GRANT_FETCH : GRANT_DATA;
               stateNext = reqBad ? ST_RESP : ST_ISSUE;
               respErr   = reqBad;
            end
         end
         ST_ISSUE: stateNext = ST_WAIT;
         ST_WAIT: begin
            if (ramMFC || timerExpired) begin
               stateNext = ST_RESP;
               respErr   = timeoutHit;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
      enterResp = (stateNext == ST_RESP) && (state != ST_RESP);
   end

   // Done/Err are launched on the edge entering RESP so they are high exactly during RESP.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         grant       <= GRANT_DATA;
         latRW       <= RW_READ;
         latSize     <= SZ_BYTE;
         latAddr     <= '0;
         latWData    <= '0;
         burstCnt    <= '0;
         fDone       <= 1'b0;
         fErr        <= 1'b0;
         dDone       <= 1'b0;
         dErr        <= 1'b0;
         rData       <= '0;
         busError    <= 1'b0;
         ramMFA      <= 1'b0;
         ramRW       <= RW_READ;
         ramDataSize <= SZ_BYTE;
         ramAddress  <= '0;
         ramDataOut  <= '0;
      end else begin
         state    <= stateNext;
         grant    <= grantNext;
         fDone    <= enterResp && (grantNext == GRANT_FETCH);
         dDone    <= enterResp && (grantNext == GRANT_DATA);
         fErr     <= enterResp && (grantNext == GRANT_FETCH) && respErr;
         dErr     <= enterResp && (grantNext == GRANT_DATA) && respErr;
         busError <= timeoutHit;

         if (state == ST_IDLE) begin
            if (!fReq || fetchWins) begin
               burstCnt <= '0;
            end else if (dataWins) begin
               burstCnt <= burstCnt + 1'b1;
            end

            if (fetchWins) begin
               latRW    <= RW_READ;
               latSize  <= SZ_WORD;
               latAddr  <= fAddr;
               latWData <= '0;
            end else if (dataWins) begin
               latRW    <= dRW;
               latSize  <= dSize;
               latAddr  <= dAddr;
               latWData <= dWData;
            end
         end

         if (state == ST_ISSUE) begin
            ramMFA      <= 1'b1;
            ramRW       <= latRW;
            ramDataSize <= latSize;
            ramAddress  <= latAddr;
            ramDataOut  <= latWData;
         end

         if ((state == ST_WAIT) && (ramMFC || timerExpired)) begin
            ramMFA <= 1'b0;
         end

         if ((state == ST_WAIT) && ramMFC && (latRW == RW_READ)) begin
            rData <= ramDataIn;
         end
      end
   end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed self-checking bench for ram_access_arbiter with a simple RAM responder
// that raises MFC after a programmable number of WAIT cycles.
module tb_ram_access_arbiter;

   logic        Clk = 1'b0;
   logic        reset;
   logic        fReq;
   logic [8:0]  fAddr;
   logic        fDone;
   logic        fErr;
   logic        dReq;
   logic        dRW;
   logic [1:0]  dSize;
   logic [8:0]  dAddr;
   logic [31:0] dWData;
   logic        dDone;
   logic        dErr;
   logic [31:0] rData;
   logic        busError;
   logic        ramMFA;
   logic        ramRW;
   logic [1:0]  ramDataSize;
   logic [8:0]  ramAddress;
   logic [31:0] ramDataOut;
   logic [31:0] ramDataIn;
   logic        ramMFC = 1'b0;

   int passCnt  = 0;
   int totalCnt = 0;

   // WAIT cycles before MFC is seen by the arbiter; 0 means MFC never comes.
   int mfcDelay = 1;
   int waitCnt  = 0;

   int          lat;
   int          mfaCnt;
   logic        gotF, gotD, errF, errD, busE;
   logic [8:0]  addrSeen;
   logic [1:0]  sizeSeen;
   logic        rwSeen;
   logic [31:0] doutSeen;
   logic [11:0] fetchSeq;
   int          nDone;
   logic        seenMfa;
   logic        sawDone;

   always #5 Clk = ~Clk;

   ram_access_arbiter #(
      .ADDR_W     (9),
      .DATA_W     (32),
      .TIMEOUT    (64),
      .MAX_DBURST (4)
   ) dut (
      .Clk         (Clk),
      .reset       (reset),
      .fReq        (fReq),
      .fAddr       (fAddr),
      .fDone       (fDone),
      .fErr        (fErr),
      .dReq        (dReq),
      .dRW         (dRW),
      .dSize       (dSize),
      .dAddr       (dAddr),
      .dWData      (dWData),
      .dDone       (dDone),
      .dErr        (dErr),
      .rData       (rData),
      .busError    (busError),
      .ramMFA      (ramMFA),
      .ramRW       (ramRW),
      .ramDataSize (ramDataSize),
      .ramAddress  (ramAddress),
      .ramDataOut  (ramDataOut),
      .ramDataIn   (ramDataIn),
      .ramMFC      (ramMFC)
   );

   always @(posedge Clk) begin
      #1;
      if (ramMFA) begin
         waitCnt++;
         ramMFC = (mfcDelay != 0) && (waitCnt >= mfcDelay);
      end else begin
         waitCnt = 0;
         ramMFC  = 1'b0;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) begin
         passCnt++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The cycle in which the request is raised counts as cycle 1; requests drop once Done is seen.
   task runAccess(input int limit);
      lat    = 1;
      mfaCnt = 0;
      addrSeen = '0; sizeSeen = '0; rwSeen = 1'b0; doutSeen = '0;
      do begin
         tick();
         lat++;
         if (ramMFA) begin
            mfaCnt++;
            addrSeen = ramAddress;
            sizeSeen = ramDataSize;
            rwSeen   = ramRW;
            doutSeen = ramDataOut;
         end
      end while (!(fDone || dDone) && lat < limit);
      gotF = fDone; gotD = dDone; errF = fErr; errD = dErr; busE = busError;
      fReq = 1'b0;
      dReq = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      fReq = 1'b0; fAddr = '0;
      dReq = 1'b0; dRW = 1'b0; dSize = 2'b00; dAddr = '0; dWData = '0;
      ramDataIn = '0;
      tick(); tick();
      check("reset outputs", {ramMFA, fDone, fErr, dDone, dErr, busError, ramRW}, 0);
      check("reset rData", rData, 0);
      check("reset ramAddress", ramAddress, 0);
      reset = 1'b1;
      tick();

      // 1: word read, two WAIT cycles
      mfcDelay = 2; ramDataIn = 32'hDEADBEEF;
      dReq = 1'b1; dRW = 1'b0; dSize = 2'b10; dAddr = 9'h010;
      runAccess(20);
      check("t1 latency", lat, 5);
      check("t1 dDone", {gotF, gotD}, 2'b01);
      check("t1 dErr", errD, 0);
      check("t1 rData", rData, 32'hDEADBEEF);
      check("t1 ramAddress", addrSeen, 9'h010);
      check("t1 ramDataSize", sizeSeen, 2'b10);
      check("t1 mfa cycles", mfaCnt, 2);
      tick();
      check("t1 done pulse", {fDone, dDone}, 0);

      // 2: both requesters held high, immediate MFC
      mfcDelay = 1; ramDataIn = 32'h12345678;
      fReq = 1'b1; fAddr = 9'h100;
      dReq = 1'b1; dRW = 1'b0; dSize = 2'b10; dAddr = 9'h020;
      nDone = 0; fetchSeq = '0;
      for (int i = 0; i < 70 && nDone < 12; i++) begin
         tick();
         if (fDone || dDone) begin
            fetchSeq[nDone] = fDone;
            nDone++;
         end
      end
      fReq = 1'b0; dReq = 1'b0;
      check("t2 access count", nDone, 12);
      check("t2 grant order", fetchSeq, 12'h210);
      check("t2 rData", rData, 32'h12345678);
      tick();

      // 3: misaligned word write
      dReq = 1'b1; dRW = 1'b1; dSize = 2'b10; dAddr = 9'h002; dWData = 32'hCAFEF00D;
      runAccess(20);
      check("t3 latency", lat, 2);
      check("t3 dDone dErr", {gotF, gotD, errD}, 3'b011);
      check("t3 no ram access", mfaCnt, 0);
      check("t3 rData kept", rData, 32'h12345678);
      tick();

      // 4: fetch timeout
      mfcDelay = 0;
      fReq = 1'b1; fAddr = 9'h100;
      runAccess(100);
      check("t4 latency", lat, 67);
      check("t4 mfa cycles", mfaCnt, 64);
      check("t4 fDone fErr", {gotF, gotD, errF}, 3'b101);
      check("t4 busError", busE, 1);
      check("t4 rData kept", rData, 32'h12345678);
      tick();
      check("t4 busError pulse", {busError, fDone}, 0);

      // 5: reset while in WAIT, then re-grant of the still-pending fetch
      fReq = 1'b1; fAddr = 9'h0C4;
      seenMfa = 1'b0;
      for (int i = 0; i < 10 && !seenMfa; i++) begin
         tick();
         seenMfa = ramMFA;
      end
      check("t5 mfa before reset", seenMfa, 1);
      tick(); tick();
      reset = 1'b0;
      #1;
      check("t5 mfa drops at reset", ramMFA, 0);
      sawDone = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         sawDone = sawDone | fDone | dDone;
      end
      check("t5 no done in reset", sawDone, 0);
      mfcDelay = 1; ramDataIn = 32'h0BADF00D;
      reset = 1'b1;
      runAccess(20);
      check("t5 latency", lat, 4);
      check("t5 fDone", {gotF, gotD, errF}, 3'b100);
      check("t5 ramAddress", addrSeen, 9'h0C4);
      check("t5 rData", rData, 32'h0BADF00D);
      tick();

      // 6: illegal size, byte read at odd address, half write, misaligned half
      dReq = 1'b1; dRW = 1'b0; dSize = 2'b11; dAddr = 9'h010;
      runAccess(20);
      check("t6 illegal latency", lat, 2);
      check("t6 illegal dErr", {gotD, errD}, 2'b11);
      check("t6 illegal no access", mfaCnt, 0);
      tick();

      ramDataIn = 32'h000000A5;
      dReq = 1'b1; dRW = 1'b0; dSize = 2'b00; dAddr = 9'h003;
      runAccess(20);
      check("t6 byte latency", lat, 4);
      check("t6 byte dErr", {gotD, errD}, 2'b10);
      check("t6 byte size", sizeSeen, 2'b00);
      check("t6 byte addr", addrSeen, 9'h003);
      check("t6 byte rData", rData, 32'h000000A5);
      tick();

      ramDataIn = 32'hFFFFFFFF;
      dReq = 1'b1; dRW = 1'b1; dSize = 2'b01; dAddr = 9'h006; dWData = 32'h0000BEEF;
      runAccess(20);
      check("t6 half write done", {gotD, errD}, 2'b10);
      check("t6 half write rw/size", {rwSeen, sizeSeen}, 3'b101);
      check("t6 half write data", doutSeen, 32'h0000BEEF);
      check("t6 half write rData kept", rData, 32'h000000A5);
      tick();

      dReq = 1'b1; dRW = 1'b0; dSize = 2'b01; dAddr = 9'h005;
      runAccess(20);
      check("t6 misaligned half", {lat[3:0], gotD, errD}, {4'd2, 2'b11});
      tick();

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
